alarm_ctrl: RTL
===============

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SECS, default 60, seconds of ringing before auto-stop (1..65535).
REQ-002 Parameter SNOOZE_MINS, default 5, snooze length in minutes (1..99).
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst_btn  in  1  reset; synchronous, active-low.
REQ-005 sec_tick  in  1  one-cycle pulse per second (seconds-counter carry).
REQ-006 cur_min  in  6  current minute, 0..59.
REQ-007 cur_hour  in  5  current hour, 0..23.
REQ-008 set_en  in  1  level; alarm-set mode.
REQ-009 inc_min_btn  in  1  one-cycle pulse, debounced; increment alarm minute.
REQ-010 inc_hour_btn  in  1  one-cycle pulse, debounced; increment alarm hour.
REQ-011 arm_sw  in  1  level; 1 = alarm enabled.
REQ-012 snooze_btn  in  1  one-cycle pulse, debounced.
REQ-013 alarm_min  out  6  stored alarm minute.
REQ-014 alarm_hour  out  5  stored alarm hour.
REQ-015 armed  out  1  high in ARMED, RINGING, SNOOZE.
REQ-016 ringing  out  1  high in RINGING only.
REQ-017 buzz  out  1  beeper drive; toggles per sec_tick while RINGING.

Function
REQ-018 All outputs registered; state/output change visible the cycle after the causing input is sampled.
REQ-019 inc_min_btn with set_en=1: alarm_min +1, 59 wraps to 0, no carry into hour.
REQ-020 inc_hour_btn with set_en=1: alarm_hour +1, 23 wraps to 0.
REQ-021 Both increment pulses in same cycle: both applied.
REQ-022 Increment pulses with set_en=0: ignored.
REQ-023 FSM states DISARMED, ARMED, RINGING, SNOOZE; arm_sw=0 forces DISARMED from any state, highest priority.
REQ-024 DISARMED -> ARMED when arm_sw=1.
REQ-025 match = (cur_hour==alarm_hour) && (cur_min==alarm_min) && set_en==0.
REQ-026 ARMED -> RINGING when match=1 and fired=0; fired set on that transition.
REQ-027 fired cleared on any cycle where cur_hour/cur_min differ from alarm time; prevents re-trigger within the matching minute after timeout.
REQ-028 RINGING: 16-bit ring counter cleared on entry, +1 per sec_tick; on the tick reaching RING_SECS -> ARMED.
REQ-029 RINGING with snooze_btn=1 -> SNOOZE, snooze counter loaded SNOOZE_MINS*60; snooze wins over simultaneous timeout.
REQ-030 SNOOZE: snooze counter -1 per sec_tick; on the tick reaching 0 -> RINGING, ring counter cleared.
REQ-031 snooze_btn outside RINGING: ignored.
REQ-032 buzz=0 on entry to RINGING, toggles on each sec_tick in RINGING, forced 0 in all other states.
REQ-033 Alarm time edits in RINGING/SNOOZE do not alter current state; fired logic uses new value next cycle.

Reset
REQ-034 rst_btn=0 at a clock edge: state DISARMED, alarm_hour=7, alarm_min=0, fired=0, counters 0, armed=0, ringing=0, buzz=0.
REQ-035 Reset mid-ring or mid-snooze takes effect next edge, overriding all other inputs.

Verification
REQ-036 Reset, set_en=1, 60 inc_min_btn pulses -> alarm_min returns to 0, alarm_hour stays 7; 17 inc_hour_btn pulses -> alarm_hour=0.
REQ-037 arm_sw=1, cur=07:00, set_en=0 -> ringing=1 one cycle after match; 60 sec_ticks -> ringing=0, armed=1; no re-ring while cur stays 07:00.
REQ-038 Ringing, snooze_btn pulse -> ringing=0, armed=1; 299 sec_ticks -> still snoozing; 300th -> ringing=1.
REQ-039 Ringing, arm_sw=0 and snooze_btn same cycle -> DISARMED, armed=0, buzz=0.
REQ-040 Ringing, 3 sec_ticks -> buzz sequence 0,1,0,1; reset asserted mid-ring -> all outputs at REQ-034 values next cycle.
REQ-041 set_en=1 with cur equal to alarm time and armed -> no ringing; set_en->0 -> ringing next cycle.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm-clock controller: stores the alarm time, detects the match against the current time,
// and sequences ringing, snooze and automatic timeout.
module alarm_ctrl #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_MINS = 5
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic       sec_tick,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hour,
  input  logic       set_en,
  input  logic       inc_min_btn,
  input  logic       inc_hour_btn,
  input  logic       arm_sw,
  input  logic       snooze_btn,
  output logic [5:0] alarm_min,
  output logic [4:0] alarm_hour,
  output logic       armed,
  output logic       ringing,
  output logic       buzz
);

  localparam logic [15:0] RingLimit  = 16'(RING_SECS);
  localparam logic [15:0] SnoozeLoad = 16'(SNOOZE_MINS * 60);

  typedef enum logic [1:0] {StDisarmed, StArmed, StRinging, StSnooze} state_e;

  state_e      state_q, state_d;
  logic [15:0] ring_cnt_q, ring_cnt_d;
  logic [15:0] snz_cnt_q, snz_cnt_d;
  logic        fired_q, fired_d;
  logic        buzz_q, buzz_d;
  logic [5:0]  alarm_min_q, alarm_min_d;
  logic [4:0]  alarm_hour_q, alarm_hour_d;
  logic        time_eq;
  logic        match;

  assign time_eq = (cur_hour == alarm_hour_q) && (cur_min == alarm_min_q);
  assign match   = time_eq && !set_en;

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      state_q      <= StDisarmed;
      ring_cnt_q   <= '0;
      snz_cnt_q    <= '0;
      fired_q      <= 1'b0;
      buzz_q       <= 1'b0;
      alarm_min_q  <= 6'd0;
      alarm_hour_q <= 5'd7;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      fired_q      <= fired_d;
      buzz_q       <= buzz_d;
      alarm_min_q  <= alarm_min_d;
      alarm_hour_q <= alarm_hour_d;
    end
  end

  // Disarm has top priority; snooze beats a simultaneous ring timeout.
  always_comb begin
    state_d = state_q;
    if (!arm_sw) begin
      state_d = StDisarmed;
    end else begin
      unique case (state_q)
        StDisarmed: state_d = StArmed;
        StArmed:    if (match && !fired_q) state_d = StRinging;
        StRinging: begin
          if (snooze_btn) begin
            state_d = StSnooze;
          end else if (sec_tick && (ring_cnt_q + 16'd1 == RingLimit)) begin
            state_d = StArmed;
          end
        end
        StSnooze:   if (sec_tick && (snz_cnt_q == 16'd1)) state_d = StRinging;
        default:    state_d = StDisarmed;
      endcase
    end
  end

  always_comb begin
    ring_cnt_d   = ring_cnt_q;
    snz_cnt_d    = snz_cnt_q;
    buzz_d       = 1'b0;
    fired_d      = fired_q;
    alarm_min_d  = alarm_min_q;
    alarm_hour_d = alarm_hour_q;

    if (state_d == StRinging && state_q != StRinging) begin
      ring_cnt_d = '0;
    end else if (state_d == StRinging && sec_tick) begin
      ring_cnt_d = ring_cnt_q + 16'd1;
    end

    if (state_d == StSnooze && state_q != StSnooze) begin
      snz_cnt_d = SnoozeLoad;
    end else if (state_q == StSnooze && sec_tick) begin
      snz_cnt_d = snz_cnt_q - 16'd1;
    end

    if (state_q == StRinging && state_d == StRinging) begin
      buzz_d = sec_tick ? ~buzz_q : buzz_q;
    end

    // Fired only latches while the time matches, so clearing on mismatch cannot collide.
    if (!time_eq) begin
      fired_d = 1'b0;
    end else if (state_q == StArmed && state_d == StRinging) begin
      fired_d = 1'b1;
    end

    if (set_en && inc_min_btn) begin
      alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
    end
    if (set_en && inc_hour_btn) begin
      alarm_hour_d = (alarm_hour_q == 5'd23) ? 5'd0 : alarm_hour_q + 5'd1;
    end
  end

  always_comb begin
    armed      = (state_q != StDisarmed);
    ringing    = (state_q == StRinging);
    buzz       = buzz_q;
    alarm_min  = alarm_min_q;
    alarm_hour = alarm_hour_q;
  end

endmodule
